// File: rtl/parse_pkt_split_pkg.sv
// Shared constants and types for the packet split stage of the parse pipeline.
package parse_pkg;

    localparam int unsigned PKT_W = 139;
    localparam int unsigned MD_W  = 360;

    // Beat tag encodings carried in in_pkt[138:136]
    localparam logic [2:0] TAG_FIRST = 3'b101;
    localparam logic [2:0] TAG_MID   = 3'b100;
    localparam logic [2:0] TAG_LAST  = 3'b110;

    // Metadata flag bit positions
    localparam int unsigned MD_DISCARD = 359;
    localparam int unsigned MD_CTL     = 358;
    localparam int unsigned MD_ERR     = 357;
    localparam int unsigned MD_NOBODY  = 356;
    localparam int unsigned MD_CUT     = 355;

    // Synthetic end beat used to close a malformed packet: tag 110, count 0, data 0
    localparam logic [PKT_W-1:0] SYNTH_END = {TAG_LAST, {(PKT_W-3){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StHead,
        StPayload,
        StDrop
    } split_state_e;

    // Rewrite the tag of a beat to TAG_LAST, keeping count and data
    function automatic logic [PKT_W-1:0] force_last(input logic [PKT_W-1:0] beat);
        logic [PKT_W-1:0] b;
        b = beat;
        b[PKT_W-1 -: 3] = TAG_LAST;
        return b;
    endfunction

endpackage

// File: rtl/parse_pkt_split_if.sv
// Bundle of the split stage's input streams, dispatch FIFO writes and status.
interface parse_pkt_split_if;
    import parse_pkg::*;

    logic              in_pkt_valid;
    logic [PKT_W-1:0]  in_pkt;
    logic              in_pkt_ready;
    logic              in_metadata_valid;
    logic [MD_W-1:0]   in_metadata;
    logic              in_metadata_ready;
    logic              pkt_head_valid;
    logic [PKT_W-1:0]  pkt_head;
    logic              pkt_payload_valid;
    logic [PKT_W-1:0]  pkt_payload;
    logic              pkt_metadata_valid;
    logic [MD_W-1:0]   pkt_metadata;
    logic              buf_addr_full;
    logic [15:0]       err_cnt;

    // Split stage view
    modport slave (
        input  in_pkt_valid, in_pkt, in_metadata_valid, in_metadata, buf_addr_full,
        output in_pkt_ready, in_metadata_ready, pkt_head_valid, pkt_head,
               pkt_payload_valid, pkt_payload, pkt_metadata_valid, pkt_metadata, err_cnt
    );

    // Upstream/downstream environment view
    modport master (
        output in_pkt_valid, in_pkt, in_metadata_valid, in_metadata, buf_addr_full,
        input  in_pkt_ready, in_metadata_ready, pkt_head_valid, pkt_head,
               pkt_payload_valid, pkt_payload, pkt_metadata_valid, pkt_metadata, err_cnt
    );

endinterface

// File: rtl/parse_pkt_split.sv
// Splits each packet into head (first HEAD_BEATS beats) and payload streams and
// emits the merged per-packet metadata alongside the packet's final write.
module parse_pkt_split
    import parse_pkg::*;
#(
    parameter int unsigned HEAD_BEATS = 8,
    parameter int unsigned MAX_BEATS  = 96
) (
    input logic               clk,
    input logic               reset,
    parse_pkt_split_if.slave  bus
);

    split_state_e      state_q, state_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              md_held_q;
    logic [MD_W-1:0]   md_reg_q;
    logic [15:0]       err_cnt_q;

    logic              head_valid_q, head_valid_d;
    logic [PKT_W-1:0]  head_q, head_d;
    logic              pay_valid_q, pay_valid_d;
    logic [PKT_W-1:0]  pay_q, pay_d;
    logic              md_valid_q, md_valid_d;
    logic [MD_W-1:0]   md_q, md_d;

    logic              pkt_ready;
    logic              pkt_accept;
    logic              md_accept;
    logic              md_take;
    logic              err_inc;
    logic [2:0]        in_tag;
    logic [7:0]        cnt_cur;
    logic              at_head_end;

    // Backpressure is only honoured at packet start; a started packet always drains
    assign pkt_ready   = (state_q != StIdle) || (md_held_q && !bus.buf_addr_full);
    assign pkt_accept  = bus.in_pkt_valid && pkt_ready;
    assign md_accept   = bus.in_metadata_valid && !md_held_q;
    assign in_tag      = bus.in_pkt[PKT_W-1 -: 3];
    assign cnt_cur     = (state_q == StIdle) ? 8'd1 : beat_cnt_q + 8'd1;
    assign at_head_end = (cnt_cur == 8'(HEAD_BEATS));

    // Next-state, stream routing and metadata merge for the accepted beat
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        head_valid_d = 1'b0;
        head_d       = head_q;
        pay_valid_d  = 1'b0;
        pay_d        = pay_q;
        md_valid_d   = 1'b0;
        md_d         = md_q;
        err_inc      = 1'b0;
        md_take      = 1'b0;

        if (pkt_accept) begin
            beat_cnt_d = cnt_cur;
            unique case (state_q)
                StIdle: begin
                    if (in_tag == TAG_FIRST) begin
                        md_take      = 1'b1;
                        head_valid_d = 1'b1;
                        head_d       = bus.in_pkt;
                        state_d      = StHead;
                        if (at_head_end) begin
                            head_d = force_last(bus.in_pkt);
                            if (md_reg_q[MD_DISCARD]) begin
                                md_valid_d            = 1'b1;
                                md_d                  = md_reg_q;
                                md_d[MD_NOBODY]       = 1'b1;
                                state_d               = StDrop;
                            end else begin
                                state_d = StPayload;
                            end
                        end
                    end else if (in_tag == TAG_LAST) begin
                        // Single-beat packet
                        md_take         = 1'b1;
                        head_valid_d    = 1'b1;
                        head_d          = bus.in_pkt;
                        md_valid_d      = 1'b1;
                        md_d            = md_reg_q;
                        md_d[MD_NOBODY] = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                StHead: begin
                    head_valid_d = 1'b1;
                    head_d       = bus.in_pkt;
                    if (in_tag == TAG_FIRST) begin
                        // New packet collided with an open one: close it, drop the newcomer
                        head_d           = SYNTH_END;
                        md_valid_d       = 1'b1;
                        md_d             = md_reg_q;
                        md_d[MD_DISCARD] = 1'b1;
                        md_d[MD_NOBODY]  = 1'b1;
                        err_inc          = 1'b1;
                        beat_cnt_d       = 8'd1;
                        state_d          = StDrop;
                    end else if (in_tag == TAG_LAST) begin
                        md_valid_d      = 1'b1;
                        md_d            = md_reg_q;
                        md_d[MD_NOBODY] = 1'b1;
                        state_d         = StIdle;
                    end else if (at_head_end) begin
                        head_d = force_last(bus.in_pkt);
                        if (md_reg_q[MD_DISCARD]) begin
                            md_valid_d      = 1'b1;
                            md_d            = md_reg_q;
                            md_d[MD_NOBODY] = 1'b1;
                            state_d         = StDrop;
                        end else begin
                            state_d = StPayload;
                        end
                    end
                end
                StPayload: begin
                    pay_valid_d = 1'b1;
                    pay_d       = bus.in_pkt;
                    if (in_tag == TAG_FIRST) begin
                        pay_d           = SYNTH_END;
                        md_valid_d      = 1'b1;
                        md_d            = md_reg_q;
                        md_d[MD_ERR]    = 1'b1;
                        md_d[MD_NOBODY] = 1'b0;
                        err_inc         = 1'b1;
                        beat_cnt_d      = 8'd1;
                        state_d         = StDrop;
                    end else if (in_tag == TAG_LAST) begin
                        md_valid_d      = 1'b1;
                        md_d            = md_reg_q;
                        md_d[MD_NOBODY] = 1'b0;
                        state_d         = StIdle;
                    end else if (cnt_cur == 8'(MAX_BEATS)) begin
                        // Runaway packet: truncate here, downstream still drains payload
                        pay_d           = force_last(bus.in_pkt);
                        md_valid_d      = 1'b1;
                        md_d            = md_reg_q;
                        md_d[MD_ERR]    = 1'b1;
                        md_d[MD_NOBODY] = 1'b0;
                        err_inc         = 1'b1;
                        state_d         = StDrop;
                    end
                end
                StDrop: begin
                    if (in_tag == TAG_LAST) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            beat_cnt_q   <= 8'd0;
            err_cnt_q    <= 16'd0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            pay_valid_q  <= 1'b0;
            pay_q        <= '0;
            md_valid_q   <= 1'b0;
            md_q         <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
            pay_valid_q  <= pay_valid_d;
            pay_q        <= pay_d;
            md_valid_q   <= md_valid_d;
            md_q         <= md_d;
            if (err_inc && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // One-entry metadata holding register, freed when its packet's first beat is taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_held_q <= 1'b0;
            md_reg_q  <= '0;
        end else if (md_accept) begin
            md_held_q <= 1'b1;
            md_reg_q  <= bus.in_metadata;
        end else if (md_take) begin
            md_held_q <= 1'b0;
        end
    end

    assign bus.in_pkt_ready       = pkt_ready;
    assign bus.in_metadata_ready  = !md_held_q;
    assign bus.pkt_head_valid     = head_valid_q;
    assign bus.pkt_head           = head_q;
    assign bus.pkt_payload_valid  = pay_valid_q;
    assign bus.pkt_payload        = pay_q;
    assign bus.pkt_metadata_valid = md_valid_q;
    assign bus.pkt_metadata       = md_q;
    assign bus.err_cnt            = err_cnt_q;

endmodule
